// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sync polarity, colour width and the colour-bar helpers
// used by vga_sync_gen and its delay line.
package vga_pkg;

  localparam int CNT_W   = 10;
  localparam int COLOR_W = 4;

  localparam int DEF_TOTAL_COLS    = 800;
  localparam int DEF_TOTAL_ROWS    = 525;
  localparam int DEF_ACTIVE_COLS   = 640;
  localparam int DEF_ACTIVE_ROWS   = 480;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_PULSE  = 96;
  localparam int DEF_H_BACK_PORCH  = 48;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_PULSE  = 2;
  localparam int DEF_V_BACK_PORCH  = 33;
  localparam int DEF_VIDEO_LATENCY = 2;

  // Level driven on HSync/VSync during the pulse
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef logic [CNT_W-1:0]   count_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } timing_t;

  typedef struct packed {
    color_t red;
    color_t grn;
    color_t blu;
  } rgb_t;

  // Which of the eight vertical bars a column falls in
  function automatic logic [2:0] bar_index(input count_t col, input count_t bar_w);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      idx = (col >= count_t'(k) * bar_w) ? 3'(k) : idx;
    end
    return idx;
  endfunction

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    c.red = idx[0] ? 4'hF : 4'h0;
    c.grn = idx[1] ? 4'hF : 4'h0;
    c.blu = idx[2] ? 4'hF : 4'h0;
    return c;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Parameterised-width, parameterised-depth shift register with asynchronous active-low
// reset to a configurable value; also exposes the value about to enter the last stage.
module sync_delay_line #(
  parameter int               WIDTH       = 3,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] prev
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain; every stage reloads the reset value while reset is asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= RESET_VALUE;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

  // prev is what dout will show after the next edge
  generate
    if (DEPTH == 1) begin : g_prev_direct
      assign prev = din;
    end else begin : g_prev_tap
      assign prev = stage_r[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters, sync generation and blanked, latency-aligned colour output.
// Define VGA_SYNC_GEN_TEST_PATTERN_EN to replace upstream colour with eight vertical bars.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS    = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_PULSE  = DEF_H_SYNC_PULSE,
  parameter int H_BACK_PORCH  = DEF_H_BACK_PORCH,
  parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_PULSE  = DEF_V_SYNC_PULSE,
  parameter int V_BACK_PORCH  = DEF_V_BACK_PORCH,
  parameter int VIDEO_LATENCY = DEF_VIDEO_LATENCY
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic [COLOR_W-1:0] i_Red,
  input  logic [COLOR_W-1:0] i_Grn,
  input  logic [COLOR_W-1:0] i_Blu,
  output logic [CNT_W-1:0]   o_Col_Count,
  output logic [CNT_W-1:0]   o_Row_Count,
  output logic               o_Active,
  output logic               o_Frame_Start,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic [COLOR_W-1:0] o_Red_Video,
  output logic [COLOR_W-1:0] o_Grn_Video,
  output logic [COLOR_W-1:0] o_Blu_Video
);

  generate
    if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH != TOTAL_COLS) begin : g_bad_h
      $error("vga_sync_gen: horizontal active+porches+sync does not equal TOTAL_COLS");
    end
    if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH != TOTAL_ROWS) begin : g_bad_v
      $error("vga_sync_gen: vertical active+porches+sync does not equal TOTAL_ROWS");
    end
    if (VIDEO_LATENCY < 0 || VIDEO_LATENCY > 3) begin : g_bad_lat
      $error("vga_sync_gen: VIDEO_LATENCY must be 0..3");
    end
  endgenerate

  localparam count_t  LAST_COL      = count_t'(TOTAL_COLS - 1);
  localparam count_t  LAST_ROW      = count_t'(TOTAL_ROWS - 1);
  localparam count_t  ACT_COLS_C    = count_t'(ACTIVE_COLS);
  localparam count_t  ACT_ROWS_C    = count_t'(ACTIVE_ROWS);
  localparam count_t  H_SYNC_START  = count_t'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam count_t  H_SYNC_END    = count_t'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam count_t  V_SYNC_START  = count_t'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam count_t  V_SYNC_END    = count_t'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_PULSE);
  localparam timing_t DLY_RESET     = '{hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE, active: 1'b0};

  count_t  col_r;
  count_t  row_r;
  logic    frame_start_r;
  logic    active_s;
  timing_t raw_s;
  timing_t dly_s;
  timing_t prev_s;
  rgb_t    colour_in_s;
  rgb_t    colour_r;
  logic [1:0] unused_prev_s;

  // Free-running raster position and end-of-frame strobe
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col_r         <= '0;
      row_r         <= '0;
      frame_start_r <= 1'b0;
    end else if (col_r == LAST_COL) begin
      col_r         <= '0;
      row_r         <= (row_r == LAST_ROW) ? count_t'(0) : row_r + count_t'(1);
      frame_start_r <= (row_r == LAST_ROW);
    end else begin
      col_r         <= col_r + count_t'(1);
      frame_start_r <= 1'b0;
    end
  end

  assign active_s = (col_r < ACT_COLS_C) && (row_r < ACT_ROWS_C);

  // Undelayed sync pulses and active flag for the current position
  always_comb begin
    raw_s        = DLY_RESET;
    raw_s.hsync  = ((col_r >= H_SYNC_START) && (col_r < H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    raw_s.vsync  = ((row_r >= V_SYNC_START) && (row_r < V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    raw_s.active = active_s;
  end

  sync_delay_line #(
    .WIDTH       ($bits(timing_t)),
    .DEPTH       (VIDEO_LATENCY + 1),
    .RESET_VALUE (DLY_RESET)
  ) u_sync_delay (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .din   (raw_s),
    .dout  (dly_s),
    .prev  (prev_s)
  );

  assign unused_prev_s = {prev_s.hsync, prev_s.vsync};

`ifdef VGA_SYNC_GEN_TEST_PATTERN_EN
  localparam count_t BAR_W    = count_t'(ACTIVE_COLS / 8);
  localparam count_t WRAP_ADJ = count_t'(TOTAL_COLS - VIDEO_LATENCY);
  localparam logic [CNT_W:0] TOTAL_COLS_W = (CNT_W+1)'(TOTAL_COLS);

  logic [CNT_W:0] pat_sum_s;
  count_t         pat_col_s;
  logic           unused_colour_s;

  // The register samples the colour for the position VIDEO_LATENCY columns behind the counters
  always_comb begin
    pat_sum_s = {1'b0, col_r} + {1'b0, WRAP_ADJ};
    if (pat_sum_s >= TOTAL_COLS_W) begin
      pat_col_s = count_t'(pat_sum_s - TOTAL_COLS_W);
    end else begin
      pat_col_s = count_t'(pat_sum_s);
    end
    colour_in_s = bar_colour(bar_index(pat_col_s, BAR_W));
  end

  assign unused_colour_s = ^{i_Red, i_Grn, i_Blu};
`else
  assign colour_in_s = '{red: i_Red, grn: i_Grn, blu: i_Blu};
`endif

  // Output colour register, blanked by the active flag aligned with the sampled colour
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      colour_r <= '0;
    end else if (prev_s.active) begin
      colour_r <= colour_in_s;
    end else begin
      colour_r <= '0;
    end
  end

  assign o_Col_Count   = col_r;
  assign o_Row_Count   = row_r;
  assign o_Active      = active_s;
  assign o_Frame_Start = frame_start_r;
  assign o_HSync       = dly_s.hsync;
  assign o_VSync       = dly_s.vsync;
  assign o_Red_Video   = colour_r.red;
  assign o_Grn_Video   = colour_r.grn;
  assign o_Blu_Video   = colour_r.blu;

endmodule
